// File: rtl/alu_ctl_stage.sv
// ----------------------------------------------------------------------------
// alu_ctl_stage
//   Registered ALU-control stage sitting between ID and EX.
//   Decodes {ALUOp, funct7, funct3} into an ALU select code and presents it to EX
//   one cycle after ID is accepted. The output is held until EX consumes it.
//   RV32M ops are run on an external mul/div unit using a start/done handshake.
//   A timeout counter aborts the op if md_done never arrives.
//   The stage stalls IF/ID while its output is blocked or a mul/div op is in flight.
//
//   Optional feature macro: ALU_CTL_MEXT_EN
//     defined   : funct7=0000001 R-type ops are sent to the mul/div unit.
//     undefined : those ops decode as illegal with the normal 1-cycle latency.
//                 md_start, md_abort and md_op stay 0, and the FSM never leaves IDLE.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_valid            ID holds a valid instruction
//   id_alu_op           ALUOp from Control
//   id_funct7/funct3    instruction fields [31:25] / [14:12]
//   flush               kill stage contents (branch/trap)
//   ex_ready            EX consumes ex_valid this cycle
//   md_done             mul/div result ready (1-cycle pulse)
//   ex_valid            ex_* outputs valid
//   ex_alu_ctl          ALU select for EX (0 when illegal)
//   ex_is_md            EX result comes from the mul/div unit
//   ex_illegal          undecodable op or mul/div timeout, qualified by ex_valid
//   md_start            1-cycle pulse starting mul/div
//   md_op               mul/div op (funct3), held while busy
//   md_abort            1-cycle pulse: mul/div cancelled (flush or timeout)
//   stall               hold IF/ID
// ----------------------------------------------------------------------------
module alu_ctl_stage #(
  parameter int ALU_OP_W  = 3,
  parameter int ALU_SEL_W = 6,
  parameter int MD_TMO    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [ALU_OP_W-1:0]  id_alu_op,
  input  logic [6:0]           id_funct7,
  input  logic [2:0]           id_funct3,
  input  logic                 flush,
  input  logic                 ex_ready,
  input  logic                 md_done,
  output logic                 ex_valid,
  output logic [ALU_SEL_W-1:0] ex_alu_ctl,
  output logic                 ex_is_md,
  output logic                 ex_illegal,
  output logic                 md_start,
  output logic [2:0]           md_op,
  output logic                 md_abort,
  output logic                 stall
);

  // ALU select encodings (0 is reserved for "no operation / illegal")
  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = ALU_SEL_W'(1);
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = ALU_SEL_W'(2);
  localparam logic [ALU_SEL_W-1:0] ALU_SLL  = ALU_SEL_W'(3);
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = ALU_SEL_W'(4);
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = ALU_SEL_W'(5);
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = ALU_SEL_W'(6);
  localparam logic [ALU_SEL_W-1:0] ALU_SRL  = ALU_SEL_W'(7);
  localparam logic [ALU_SEL_W-1:0] ALU_SRA  = ALU_SEL_W'(8);
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = ALU_SEL_W'(9);
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = ALU_SEL_W'(10);
  localparam logic [ALU_SEL_W-1:0] ALU_BNE  = ALU_SEL_W'(11);
  localparam logic [ALU_SEL_W-1:0] ALU_BLT  = ALU_SEL_W'(12);
  localparam logic [ALU_SEL_W-1:0] ALU_BGE  = ALU_SEL_W'(13);
  localparam logic [ALU_SEL_W-1:0] ALU_BLTU = ALU_SEL_W'(14);
  localparam logic [ALU_SEL_W-1:0] ALU_BGEU = ALU_SEL_W'(15);

  localparam logic [ALU_OP_W-1:0] OP_ADD    = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OP_BRANCH = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_RTYPE  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OP_ITYPE  = ALU_OP_W'(3);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam int CNT_W = $clog2(MD_TMO) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MD_TMO - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     tmo_cnt, tmo_cnt_nxt;
  logic [ALU_SEL_W-1:0] dec_sel, ctl_nxt;
  logic                 dec_illegal, dec_is_m;
  logic                 valid_nxt, illegal_nxt, is_md_nxt;
  logic                 start_nxt, abort_nxt;
  logic [2:0]           md_op_nxt;
  logic                 accept;

  assign stall  = (ex_valid & ~ex_ready) | (state != IDLE);
  assign accept = id_valid & ~stall & ~flush;

  // Instruction decode; dec_sel stays 0 on every illegal path
  always_comb begin
    dec_sel     = '0;
    dec_illegal = 1'b0;
    dec_is_m    = 1'b0;
    case (id_alu_op)
      OP_ADD: dec_sel = ALU_ADD;
      OP_BRANCH: begin
        case (id_funct3)
          3'b000:  dec_sel = ALU_SUB;
          3'b001:  dec_sel = ALU_BNE;
          3'b100:  dec_sel = ALU_BLT;
          3'b101:  dec_sel = ALU_BGE;
          3'b110:  dec_sel = ALU_BLTU;
          3'b111:  dec_sel = ALU_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_RTYPE: begin
        if (id_funct7 == F7_BASE) begin
          case (id_funct3)
            3'b000:  dec_sel = ALU_ADD;
            3'b001:  dec_sel = ALU_SLL;
            3'b010:  dec_sel = ALU_SLT;
            3'b011:  dec_sel = ALU_SLTU;
            3'b100:  dec_sel = ALU_XOR;
            3'b101:  dec_sel = ALU_SRL;
            3'b110:  dec_sel = ALU_OR;
            default: dec_sel = ALU_AND;
          endcase
        end else if (id_funct7 == F7_ALT && id_funct3 == 3'b000) begin
          dec_sel = ALU_SUB;
        end else if (id_funct7 == F7_ALT && id_funct3 == 3'b101) begin
          dec_sel = ALU_SRA;
`ifdef ALU_CTL_MEXT_EN
        end else if (id_funct7 == F7_MD) begin
          dec_is_m = 1'b1;
`endif
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_ITYPE: begin
        // Immediate forms never subtract; only the shifts look at funct7
        case (id_funct3)
          3'b000: dec_sel = ALU_ADD;
          3'b001: begin
            if (id_funct7 == F7_BASE) dec_sel = ALU_SLL;
            else                      dec_illegal = 1'b1;
          end
          3'b010: dec_sel = ALU_SLT;
          3'b011: dec_sel = ALU_SLTU;
          3'b100: dec_sel = ALU_XOR;
          3'b101: begin
            if (id_funct7 == F7_BASE)     dec_sel = ALU_SRL;
            else if (id_funct7 == F7_ALT) dec_sel = ALU_SRA;
            else                          dec_illegal = 1'b1;
          end
          3'b110:  dec_sel = ALU_OR;
          default: dec_sel = ALU_AND;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state and next-output logic. Flush always has priority. In BUSY, md_done
  // beats a timeout that falls on the same cycle.
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    valid_nxt   = ex_valid;
    ctl_nxt     = ex_alu_ctl;
    illegal_nxt = ex_illegal;
    is_md_nxt   = ex_is_md;
    start_nxt   = 1'b0;
    abort_nxt   = 1'b0;
    md_op_nxt   = md_op;
    case (state)
      IDLE: begin
        if (flush) begin
          valid_nxt = 1'b0;
        end else if (accept) begin
          if (dec_is_m) begin
            state_nxt   = BUSY;
            tmo_cnt_nxt = '0;
            start_nxt   = 1'b1;
            md_op_nxt   = id_funct3;
            valid_nxt   = 1'b0;
          end else begin
            valid_nxt   = 1'b1;
            ctl_nxt     = dec_sel;
            illegal_nxt = dec_illegal;
            is_md_nxt   = 1'b0;
          end
        end else if (ex_valid && ex_ready) begin
          valid_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
          valid_nxt = 1'b0;
        end else if (md_done) begin
          state_nxt   = IDLE;
          valid_nxt   = 1'b1;
          ctl_nxt     = ALU_ADD;
          illegal_nxt = 1'b0;
          is_md_nxt   = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt   = IDLE;
          abort_nxt   = 1'b1;
          valid_nxt   = 1'b1;
          ctl_nxt     = '0;
          illegal_nxt = 1'b1;
          is_md_nxt   = 1'b0;
        end else begin
          tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      ex_valid   <= 1'b0;
      ex_alu_ctl <= '0;
      ex_illegal <= 1'b0;
      ex_is_md   <= 1'b0;
      md_start   <= 1'b0;
      md_abort   <= 1'b0;
      md_op      <= 3'b000;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      ex_valid   <= valid_nxt;
      ex_alu_ctl <= ctl_nxt;
      ex_illegal <= illegal_nxt;
      ex_is_md   <= is_md_nxt;
      md_start   <= start_nxt;
      md_abort   <= abort_nxt;
      md_op      <= md_op_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ctl_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_ctl_stage
//   Self-checking bench for alu_ctl_stage. A behavioural model tracks the expected
//   outputs. A compare process checks the DUT against it every cycle. Literal
//   expectations from the stage's documented examples pin both the DUT and the
//   model. Directed scenarios run first, then randomized traffic.
//   The mul/div scenarios are built only when ALU_CTL_MEXT_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_ctl_stage;

  localparam int TMO = 16;

  // Expected ALU select encodings
  localparam logic [5:0] A_ADD = 6'd1,  A_SUB = 6'd2,  A_SLL  = 6'd3,  A_SLT  = 6'd4;
  localparam logic [5:0] A_SLTU = 6'd5, A_XOR = 6'd6,  A_SRL  = 6'd7,  A_SRA  = 6'd8;
  localparam logic [5:0] A_OR  = 6'd9,  A_AND = 6'd10, A_BNE  = 6'd11, A_BLT  = 6'd12;
  localparam logic [5:0] A_BGE = 6'd13, A_BLTU = 6'd14, A_BGEU = 6'd15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, flush, ex_ready, md_done;
  logic [2:0] id_alu_op, id_funct3;
  logic [6:0] id_funct7;
  logic       ex_valid, ex_is_md, ex_illegal, md_start, md_abort, stall;
  logic [5:0] ex_alu_ctl;
  logic [2:0] md_op;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  alu_ctl_stage #(.ALU_OP_W(3), .ALU_SEL_W(6), .MD_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_funct7(id_funct7), .id_funct3(id_funct3), .flush(flush),
    .ex_ready(ex_ready), .md_done(md_done), .ex_valid(ex_valid),
    .ex_alu_ctl(ex_alu_ctl), .ex_is_md(ex_is_md), .ex_illegal(ex_illegal),
    .md_start(md_start), .md_op(md_op), .md_abort(md_abort), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference decode, written as lookup tables: returns {is_m, illegal, sel[5:0]}
  function automatic logic [7:0] ref_decode(input logic [2:0] op, input logic [6:0] f7,
                                            input logic [2:0] f3);
    logic [5:0] arith [8];
    logic [5:0] br [8];
    arith = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    br    = '{A_SUB, A_BNE, 6'd0, 6'd0, A_BLT, A_BGE, A_BLTU, A_BGEU};
    if (op == 3'd0) return {2'b00, A_ADD};
    if (op == 3'd1) return (br[f3] == 6'd0) ? 8'b0100_0000 : {2'b00, br[f3]};
    if (op == 3'd2) begin
      if (f7 == 7'h00) return {2'b00, arith[f3]};
      if (f7 == 7'h20 && f3 == 3'd0) return {2'b00, A_SUB};
      if (f7 == 7'h20 && f3 == 3'd5) return {2'b00, A_SRA};
`ifdef ALU_CTL_MEXT_EN
      if (f7 == 7'h01) return 8'b1000_0000;
`endif
      return 8'b0100_0000;
    end
    if (op == 3'd3) begin
      if (f3 == 3'd1 && f7 != 7'h00) return 8'b0100_0000;
      if (f3 == 3'd5 && f7 == 7'h20) return {2'b00, A_SRA};
      if (f3 == 3'd5 && f7 != 7'h00) return 8'b0100_0000;
      return {2'b00, arith[f3]};
    end
    return 8'b0100_0000;
  endfunction

  // Behavioural model state
  logic       m_valid, m_ill, m_md, m_busy, m_start, m_abort;
  logic [5:0] m_ctl;
  logic [2:0] m_mdop;
  int         m_age;
  logic       m_stall, m_acc;
  logic [7:0] m_dec;

  assign m_stall = (m_valid && !ex_ready) || m_busy;
  assign m_acc   = id_valid && !m_stall && !flush;
  assign m_dec   = ref_decode(id_alu_op, id_funct7, id_funct3);

  // Model update: m_age counts the cycles spent waiting, starting at 1 on the
  // md_start cycle. The wait gives up at the end of cycle TMO.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_ill <= 0; m_md <= 0; m_busy <= 0; m_start <= 0;
      m_abort <= 0; m_ctl <= 0; m_mdop <= 0; m_age <= 0;
    end else begin
      m_start <= 0;
      m_abort <= 0;
      if (m_busy) begin
        if (flush) begin
          m_abort <= 1; m_busy <= 0; m_valid <= 0;
        end else if (md_done) begin
          m_busy <= 0; m_valid <= 1; m_ctl <= A_ADD; m_ill <= 0; m_md <= 1;
        end else if (m_age == TMO) begin
          m_abort <= 1; m_busy <= 0; m_valid <= 1; m_ctl <= 0; m_ill <= 1; m_md <= 0;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (flush) begin
        m_valid <= 0;
      end else if (m_acc) begin
        if (m_dec[7]) begin
          m_busy <= 1; m_age <= 1; m_start <= 1; m_mdop <= id_funct3; m_valid <= 0;
        end else begin
          m_valid <= 1; m_ill <= m_dec[6]; m_ctl <= m_dec[5:0]; m_md <= 0;
        end
      end else if (m_valid && ex_ready) begin
        m_valid <= 0;
      end
    end
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model
  task automatic checkOutput();
    compare("ex_valid", 32'(ex_valid), 32'(m_valid));
    compare("stall", 32'(stall), 32'(m_stall));
    compare("md_start", 32'(md_start), 32'(m_start));
    compare("md_abort", 32'(md_abort), 32'(m_abort));
    if (m_valid) begin
      compare("ex_alu_ctl", 32'(ex_alu_ctl), 32'(m_ctl));
      compare("ex_illegal", 32'(ex_illegal), 32'(m_ill));
      compare("ex_is_md", 32'(ex_is_md), 32'(m_md));
    end
`ifdef ALU_CTL_MEXT_EN
    if (m_busy) compare("md_op", 32'(md_op), 32'(m_mdop));
`else
    compare("md_op", 32'(md_op), 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    #2;
    if (cmp_en) checkOutput();
  end

  // A hand-computed value checked against both the DUT and the model
  task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                          input logic [31:0] exp);
    compare(name, act, exp);
    compare({name, "_model"}, mdl, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [6:0] f7,
                               input logic [2:0] f3, input logic fl, input logic rdy,
                               input logic done);
    @(negedge clk);
    id_valid = v; id_alu_op = op; id_funct7 = f7; id_funct3 = f3;
    flush = fl; ex_ready = rdy; md_done = done;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 3'd0, 7'd0, 3'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic startMulDiv(input logic [2:0] f3);
    applyStimulus(1'b1, 3'd2, 7'h01, f3, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 0; id_valid = 0; id_alu_op = 0; id_funct7 = 0; id_funct3 = 0;
    flush = 0; ex_ready = 1; md_done = 0;
    repeat (2) @(negedge clk);
    cmp_en = 1;
    #3;
    checkLit("reset_ex_valid", 32'(ex_valid), 32'(m_valid), 0);
    checkLit("reset_stall", 32'(stall), 32'(m_stall), 0);
    @(negedge clk);
    rst_n = 1;
    idle(1);

    // R-type SRA, latency 1
    applyStimulus(1, 3'd2, 7'h20, 3'd5, 0, 1, 0);
    idle(1); #3;
    checkLit("sra_valid", 32'(ex_valid), 32'(m_valid), 1);
    checkLit("sra_ctl", 32'(ex_alu_ctl), 32'(m_ctl), 32'(A_SRA));

    // I-type f3=000 ignores funct7: always ADD
    applyStimulus(1, 3'd3, 7'h20, 3'd0, 0, 1, 0);
    idle(1); #3;
    checkLit("iadd_ctl", 32'(ex_alu_ctl), 32'(m_ctl), 32'(A_ADD));
    checkLit("iadd_illegal", 32'(ex_illegal), 32'(m_ill), 0);

    // Branch with an unused funct3 is illegal
    applyStimulus(1, 3'd1, 7'h00, 3'd2, 0, 1, 0);
    idle(1); #3;
    checkLit("br_ill_valid", 32'(ex_valid), 32'(m_valid), 1);
    checkLit("br_ill_flag", 32'(ex_illegal), 32'(m_ill), 1);
    checkLit("br_ill_ctl", 32'(ex_alu_ctl), 32'(m_ctl), 0);

    // Output held while EX is not ready
    applyStimulus(1, 3'd0, 7'h00, 3'd0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      idle(0); #3;
      checkLit("hold_stall", 32'(stall), 32'(m_stall), 1);
      checkLit("hold_ctl", 32'(ex_alu_ctl), 32'(m_ctl), 32'(A_ADD));
    end
    idle(1); #3;
    checkLit("hold_release_stall", 32'(stall), 32'(m_stall), 0);
    idle(1); #3;
    checkLit("hold_cleared", 32'(ex_valid), 32'(m_valid), 0);

    // Flush with id_valid captures nothing; flush kills a held output
    applyStimulus(1, 3'd0, 7'h00, 3'd0, 1, 1, 0);
    idle(1); #3;
    checkLit("flush_id_valid", 32'(ex_valid), 32'(m_valid), 0);
    applyStimulus(1, 3'd2, 7'h00, 3'd4, 0, 0, 0);
    applyStimulus(0, 3'd0, 7'h00, 3'd0, 1, 0, 0);
    idle(1); #3;
    checkLit("flush_held", 32'(ex_valid), 32'(m_valid), 0);

`ifdef ALU_CTL_MEXT_EN
    // Normal mul/div: done arrives 10 cycles after start
    startMulDiv(3'd4);
    idle(1); #3;
    checkLit("md_start", 32'(md_start), 32'(m_start), 1);
    checkLit("md_op", 32'(md_op), 32'(m_mdop), 4);
    checkLit("md_stall", 32'(stall), 32'(m_stall), 1);
    for (int i = 1; i < 10; i++) idle(1);
    applyStimulus(0, 3'd0, 7'h00, 3'd0, 0, 1, 1);
    idle(1); #3;
    checkLit("md_done_valid", 32'(ex_valid), 32'(m_valid), 1);
    checkLit("md_done_is_md", 32'(ex_is_md), 32'(m_md), 1);
    checkLit("md_done_stall", 32'(stall), 32'(m_stall), 0);
    // md_done while IDLE is ignored
    applyStimulus(0, 3'd0, 7'h00, 3'd0, 0, 1, 1);
    idle(1); #3;
    checkLit("done_in_idle", 32'(ex_valid), 32'(m_valid), 0);

    // Timeout: abort appears TMO cycles after the md_start cycle
    startMulDiv(3'd1);
    for (int i = 0; i <= TMO; i++) begin
      idle(1); #3;
      if (i == TMO - 1) checkLit("tmo_early", 32'(md_abort), 32'(m_abort), 0);
      if (i == TMO) begin
        checkLit("tmo_abort", 32'(md_abort), 32'(m_abort), 1);
        checkLit("tmo_valid", 32'(ex_valid), 32'(m_valid), 1);
        checkLit("tmo_illegal", 32'(ex_illegal), 32'(m_ill), 1);
      end
    end

    // Flush at cycle 5 aborts at cycle 6; a later md_done is ignored
    startMulDiv(3'd6);
    for (int i = 0; i < 5; i++) idle(1);
    applyStimulus(0, 3'd0, 7'h00, 3'd0, 1, 1, 0);
    idle(1); #3;
    checkLit("flush_abort", 32'(md_abort), 32'(m_abort), 1);
    checkLit("flush_no_valid", 32'(ex_valid), 32'(m_valid), 0);
    applyStimulus(0, 3'd0, 7'h00, 3'd0, 0, 1, 1);
    idle(1); #3;
    checkLit("late_done", 32'(ex_valid), 32'(m_valid), 0);

    // md_done on the timeout cycle wins
    startMulDiv(3'd2);
    for (int i = 0; i < TMO - 1; i++) idle(1);
    applyStimulus(0, 3'd0, 7'h00, 3'd0, 0, 1, 1);
    idle(1); #3;
    checkLit("tmo_done_valid", 32'(ex_valid), 32'(m_valid), 1);
    checkLit("tmo_done_is_md", 32'(ex_is_md), 32'(m_md), 1);
    checkLit("tmo_done_abort", 32'(md_abort), 32'(m_abort), 0);

    // Flush together with md_done: flush wins
    startMulDiv(3'd3);
    for (int i = 0; i < 3; i++) idle(1);
    applyStimulus(0, 3'd0, 7'h00, 3'd0, 1, 1, 1);
    idle(1); #3;
    checkLit("flush_done_abort", 32'(md_abort), 32'(m_abort), 1);
    checkLit("flush_done_valid", 32'(ex_valid), 32'(m_valid), 0);

    // Reset while busy: straight back to reset values with no abort pulse
    startMulDiv(3'd7);
    for (int i = 0; i < 4; i++) idle(1);
    #1 rst_n = 0;
    #2;
    checkLit("rst_busy_abort", 32'(md_abort), 32'(m_abort), 0);
    checkLit("rst_busy_stall", 32'(stall), 32'(m_stall), 0);
    checkLit("rst_busy_md_op", 32'(md_op), 32'(m_mdop), 0);
    @(negedge clk);
    rst_n = 1;
`else
    // Without the mul/div extension, funct7=0000001 is illegal with latency 1
    startMulDiv(3'd4);
    idle(1); #3;
    checkLit("m_illegal_valid", 32'(ex_valid), 32'(m_valid), 1);
    checkLit("m_illegal_flag", 32'(ex_illegal), 32'(m_ill), 1);
    checkLit("m_illegal_start", 32'(md_start), 32'(m_start), 0);
    checkLit("m_illegal_stall", 32'(stall), 32'(m_stall), 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [6:0] f7;
      logic [2:0] op;
      int r;
      r = $urandom_range(0, 3);
      f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : (r == 2) ? 7'h01 : 7'($urandom);
      r = $urandom_range(0, 9);
      op = (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7));
      applyStimulus($urandom_range(0, 3) != 0, op, f7, 3'($urandom),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0);
    end

    idle(1);
    idle(1);
    @(negedge clk);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
